// File: rtl/prio_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : prio_arbiter_ctrl
//  Brief    : 8-requester arbiter with fixed-priority / round-robin selection,
//             grant hold until release, request drop or hold timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module prio_arbiter_ctrl #(
    parameter int NUM_REQ  = 8,
    parameter int MAX_HOLD = 16,
    parameter int HCNT_W   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               rr_en,
    input  logic               req_release,
    output logic [NUM_REQ-1:0] grant,
    output logic [2:0]         grant_id,
    output logic               grant_valid,
    output logic               timeout
);

    localparam int          c_ID_W         = 3;
    localparam bit          c_HOLD_LIMITED = (MAX_HOLD != 0);
    localparam [HCNT_W-1:0] c_HOLD_MAX     = HCNT_W'(MAX_HOLD);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t              state_q,       state_d;
    logic [NUM_REQ-1:0]  grant_q,       grant_d;
    logic [c_ID_W-1:0]   grant_id_q,    grant_id_d;
    logic                grant_valid_q, grant_valid_d;
    logic                timeout_q,     timeout_d;
    logic [HCNT_W-1:0]   hold_cnt_q,    hold_cnt_d;
    logic [c_ID_W-1:0]   last_id_q,     last_id_d;

    logic [c_ID_W-1:0]   win_id;
    logic [c_ID_W-1:0]   rr_idx;
    logic                rr_found;
    logic                owner_drop;
    logic                hold_expired;

    // Round-robin walks downward from one below the last winner, wrapping 0 -> 7.
    always_comb begin
        win_id   = '0;
        rr_idx   = '0;
        rr_found = 1'b0;
        if (rr_en) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                rr_idx = last_id_q - c_ID_W'(1) - c_ID_W'(i);
                if (!rr_found && req[rr_idx]) begin
                    win_id   = rr_idx;
                    rr_found = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req[i]) begin
                    win_id = c_ID_W'(i);
                end
            end
        end
    end

    assign owner_drop   = !req[grant_id_q];
    assign hold_expired = c_HOLD_LIMITED && (hold_cnt_q == c_HOLD_MAX);

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
        timeout_d     = 1'b0;
        hold_cnt_d    = hold_cnt_q;
        last_id_d     = last_id_q;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d       = BUSY;
                    grant_d       = NUM_REQ'(1) << win_id;
                    grant_id_d    = win_id;
                    grant_valid_d = 1'b1;
                    hold_cnt_d    = HCNT_W'(1);
                    last_id_d     = win_id;
                end
            end
            BUSY: begin
                if (req_release || owner_drop || hold_expired) begin
                    state_d       = IDLE;
                    grant_d       = '0;
                    grant_id_d    = '0;
                    grant_valid_d = 1'b0;
                    hold_cnt_d    = '0;
                    timeout_d     = !req_release && !owner_drop;
                end else if (hold_cnt_q != {HCNT_W{1'b1}}) begin
                    hold_cnt_d = hold_cnt_q + HCNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            hold_cnt_q    <= '0;
            last_id_q     <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            timeout_q     <= timeout_d;
            hold_cnt_q    <= hold_cnt_d;
            last_id_q     <= last_id_d;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = grant_id_q;
    assign grant_valid = grant_valid_q;
    assign timeout     = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_prio_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prio_arbiter_ctrl
//  Brief    : Directed and randomized bench for prio_arbiter_ctrl against an
//             owner/tenure model of the arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prio_arbiter_ctrl;

    localparam int c_MAX_HOLD = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'hFF;
    logic       rr_en = 1'b0;
    logic       req_release = 1'b0;
    logic [7:0] grant;
    logic [2:0] grant_id;
    logic       grant_valid;
    logic       timeout;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    // Model: who owns the resource (-1 = nobody), cycles held, last winner.
    int m_owner = -1;
    int m_held  = 0;
    int m_last  = 0;
    bit m_to    = 1'b0;

    prio_arbiter_ctrl #(.NUM_REQ(8), .MAX_HOLD(c_MAX_HOLD), .HCNT_W(5)) dut (
        .clk(clk), .rst(rst), .req(req), .rr_en(rr_en), .req_release(req_release),
        .grant(grant), .grant_id(grant_id), .grant_valid(grant_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [7:0] r, input bit rr, input int last);
        int w;
        int c;
        w = -1;
        for (int k = 1; k <= 8; k++) begin
            c = rr ? (last - k + 8) % 8 : 8 - k;
            if (w < 0 && r[c]) w = c;
        end
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk) begin
        m_to = 1'b0;
        if (rst) begin
            m_owner = -1;
            m_held  = 0;
            m_last  = 0;
        end else if (m_owner < 0) begin
            if (req != 8'h00) begin
                m_owner = pick(req, rr_en, m_last);
                m_held  = 1;
                m_last  = m_owner;
            end
        end else if (req_release || !req[m_owner]) begin
            m_owner = -1;
        end else if (c_MAX_HOLD != 0 && m_held >= c_MAX_HOLD) begin
            m_owner = -1;
            m_to    = 1'b1;
        end else begin
            m_held++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("grant",       {24'd0, grant},       (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            chk("grant_id",    {29'd0, grant_id},    (m_owner >= 0) ? m_owner : 0);
            chk("grant_valid", {31'd0, grant_valid}, {31'd0, m_owner >= 0});
            chk("timeout",     {31'd0, timeout},     {31'd0, m_to});
            if (grant_valid) chk("onehot", {24'd0, grant}, 32'd1 << grant_id);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rel_pulse();
        req_release = 1'b1;
        tick();
        req_release = 1'b0;
    endtask

    initial begin
        int rr_exp[9];
        rr_exp = '{7, 6, 5, 4, 3, 2, 1, 0, 7};

        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_grant", {24'd0, grant}, 32'h0);
        chk("rst_valid", {31'd0, grant_valid}, 32'h0);
        rst = 1'b0;
        tick();
        chk("first_grant", {24'd0, grant}, 32'h80);
        chk("first_id", {29'd0, grant_id}, 32'd7);

        req = 8'b0001_0100;
        rel_pulse();
        chk("gap_after_rel", {31'd0, grant_valid}, 32'd0);
        tick();
        chk("fixed_id4", {29'd0, grant_id}, 32'd4);
        rel_pulse();
        chk("gap_fixed", {31'd0, grant_valid}, 32'd0);
        tick();
        chk("fixed_id4_again", {29'd0, grant_id}, 32'd4);

        rst = 1'b1; rr_en = 1'b1; req = 8'hFF;
        tick();
        rst = 1'b0;
        tick();
        chk("rr_id_0", {29'd0, grant_id}, rr_exp[0]);
        for (int i = 1; i < 9; i++) begin
            rel_pulse();
            chk("rr_gap", {31'd0, grant_valid}, 32'd0);
            tick();
            chk("rr_id", {29'd0, grant_id}, rr_exp[i]);
        end

        rr_en = 1'b0; req = 8'h02;
        rel_pulse();
        tick();
        for (int i = 0; i < 16; i++) begin
            chk("hold_id1", {29'd0, grant_id}, 32'd1);
            chk("hold_valid", {31'd0, grant_valid}, 32'd1);
            if (i < 15) tick();
        end
        tick();
        chk("timeout_pulse", {31'd0, timeout}, 32'd1);
        chk("timeout_drop", {31'd0, grant_valid}, 32'd0);
        tick();
        chk("timeout_single", {31'd0, timeout}, 32'd0);
        chk("regrant_id1", {29'd0, grant_id}, 32'd1);

        req = 8'h42;
        tick();
        chk("no_preempt", {29'd0, grant_id}, 32'd1);
        req = 8'h40;
        tick();
        chk("drop_ends", {31'd0, grant_valid}, 32'd0);
        tick();
        chk("then_id6", {29'd0, grant_id}, 32'd6);

        rst = 1'b1;
        tick();
        chk("midrst_grant", {24'd0, grant}, 32'h0);
        chk("midrst_valid", {31'd0, grant_valid}, 32'd0);
        rst = 1'b0; rr_en = 1'b1; req = 8'h81;
        tick();
        chk("rr_after_rst", {29'd0, grant_id}, 32'd7);

        for (int i = 0; i < 4000; i++) begin
            req         = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 5) == 0) req = req | 8'($urandom);
            rr_en       = $urandom_range(0, 1) == 1;
            req_release = $urandom_range(0, 9) == 0;
            rst         = $urandom_range(0, 199) == 0;
            if (i % 500 < 60) begin
                req         = grant_valid ? grant : 8'h10;
                req_release = 1'b0;
                rst         = 1'b0;
            end
            tick();
        end
        rst = 1'b0; req_release = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prio_arbiter_ctrl.md
Name: prio_arbiter_ctrl

Overview:
- Sequential arbiter that shares one resource among 8 requesters.
- Uses the team's 8:3 priority convention: bit 7 is highest.
- Fixed-priority mode: plain priority encoding.
- Round-robin mode: rotates the starting point past the last winner.
- Holds each grant until release, request drop or hold timeout. Sits in front of any shared datapath (bus, memory port, encoder-fed mux).

Parameters:
- NUM_REQ, 8, number of requesters (fixed at 8; ID width 3).
- MAX_HOLD, 16, max cycles a grant may be held; 0 = unlimited.
- HCNT_W, 5, hold counter width, >= clog2(MAX_HOLD+1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  8  request vector; req[i] high = requester i wants resource.
- rr_en  input  1  1 = round-robin, 0 = fixed priority; sampled only at arbitration.
- release  input  1  one-cycle pulse from current owner ending its tenure.
- grant  output  8  one-hot grant, registered.
- grant_id  output  3  binary index of granted requester, registered.
- grant_valid  output  1  high while any grant is held.
- timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Behaviour:
- Reset (clk edge with rst=1):
  - grant=0, grant_id=0, grant_valid=0, timeout=0.
  - state=IDLE, last_id=0, hold_cnt=0.
  - Applies mid-grant as well: the grant drops on that edge.
- States: IDLE, BUSY.
- IDLE:
  - If req==0, stay; outputs remain 0.
  - If req!=0, compute winner W combinationally and register it: grant=1<<W, grant_id=W, grant_valid=1, hold_cnt=1, last_id=W, go to BUSY.
  - Latency: req sampled at edge N, grant visible after edge N (1 cycle).
- Winner selection:
  - Fixed mode (rr_en=0): highest set index of req. Same table as the 8:3 priority encoder: D[7] -> 7, ..., D[0] -> 0.
  - Round-robin mode (rr_en=1): search descending starting at (last_id-1) mod 8, wrapping 0 -> 7; the first set bit wins.
  - last_id resets to 0, so the first RR search starts at 7 (identical to fixed mode).
  - A requester that just won gets lowest priority next round.
- BUSY: grant outputs held constant. Each cycle, evaluate end conditions in this order:
  - release=1 -> end, timeout=0.
  - req[grant_id]=0 -> end (owner abandoned), timeout=0.
  - MAX_HOLD!=0 and hold_cnt==MAX_HOLD -> end, timeout=1 for exactly one cycle, coincident with the grant dropping.
  - else hold_cnt++ (saturating; no wrap when MAX_HOLD=0).
- On end: next edge clears grant, grant_id, grant_valid and returns to IDLE.
- Mandatory 1-cycle gap:
  - Back-to-back grants are separated by at least one IDLE cycle with grant_valid=0. This gives the datapath a turnaround cycle.
  - Re-arbitration happens in that IDLE cycle; the earliest new grant comes 2 edges after the end condition.
- Other boundary rules:
  - release while in IDLE: ignored.
  - New requests arriving during BUSY: ignored until IDLE (no preemption, even by a higher-priority requester).
  - rr_en toggling during BUSY: no effect on the current grant.
  - last_id updates in both modes, so switching to RR continues from the last winner.
- Invariants:
  - grant is always one-hot or zero.
  - grant == (1<<grant_id) whenever grant_valid=1.
  - timeout never asserts while grant_valid=0 is already held from the prior cycle.

Test Plan:
- rst high 2 cycles with req=8'hFF -> all outputs 0. Release rst, req=8'hFF, rr_en=0 -> next cycle grant=8'h80, grant_id=7, grant_valid=1.
- Fixed mode, req=8'b0001_0100 -> grant_id=4. Pulse release -> grant_valid=0 one cycle. Req unchanged -> grant_id=4 again.
- RR mode, req=8'hFF held, release after each grant -> grant_id sequence 7,6,5,4,3,2,1,0,7 with one idle cycle between each.
- MAX_HOLD=16, req=8'h02 held, no release -> grant_id=1 for exactly 16 cycles. Then grant drops with timeout=1 for one cycle and re-grants after the idle cycle.
- Owner drops req mid-grant while req[6] rises during BUSY -> no preemption. Grant ends the cycle after the drop, then grant_id=6.
- Assert rst while grant_valid=1 -> all outputs 0 on that edge. After release of rst in RR mode with req=8'h81 -> grant_id=7 (last_id reset).
